// File: rtl/centroid_pkg.sv
// Shared types and defaults for the centroid accumulator: FSM state encoding,
// divider/threshold defaults and the timeout counter sizing helper.
package centroid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START_X = 3'd1,
    ST_WAIT_X  = 3'd2,
    ST_START_Y = 3'd3,
    ST_WAIT_Y  = 3'd4,
    ST_PUBLISH = 3'd5
  } state_t;

  function automatic int tmo_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int DIV_W_DEF      = 32;
  localparam int MIN_PIXELS_DEF = 64;
  localparam int TIMEOUT_DEF    = 80;
  localparam int TMO_W_DEF      = tmo_width(TIMEOUT_DEF);

endpackage

// File: rtl/centroid_accumulator_if.sv
// Handshake bus between the centroid accumulator (master) and the restoring
// divider (slave).
interface centroid_accumulator_if
  import centroid_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
);

  logic             div_start;
  logic             div_sign;
  logic [DIV_W-1:0] div_dividend;
  logic [DIV_W-1:0] div_divisor;
  logic [DIV_W-1:0] div_quotient;
  logic             div_ready;

  modport master (
    output div_start, div_sign, div_dividend, div_divisor,
    input  div_quotient, div_ready
  );

  modport slave (
    input  div_start, div_sign, div_dividend, div_divisor,
    output div_quotient, div_ready
  );

endinterface

// File: rtl/centroid_sum_accum.sv
// Saturating per-frame x/y/count accumulators with a sticky overflow flag,
// clear on frame_end and a snapshot of the closing frame for the divider.
module centroid_sum_accum
  import centroid_pkg::*;
#(
  parameter int X_W   = 10,
  parameter int Y_W   = 10,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             pix_hit,
  input  logic [X_W-1:0]   hcount,
  input  logic [Y_W-1:0]   vcount,
  input  logic             frame_end,
  input  logic             snap_en,
  output logic [DIV_W-1:0] close_cnt_s,
  output logic             close_ovf_s,
  output logic [DIV_W-1:0] hx,
  output logic [DIV_W-1:0] hy,
  output logic [DIV_W-1:0] hc
);

  logic [DIV_W-1:0] sx_r, sy_r, cnt_r;
  logic             ovf_r;
  logic [DIV_W-1:0] hx_r, hy_r, hc_r;
  logic [DIV_W:0]   add_x_s, add_y_s, add_c_s;
  logic [DIV_W-1:0] sum_x_s, sum_y_s;
  logic             hit_s;

  assign hit_s   = pix_valid & pix_hit;
  assign add_x_s = {1'b0, sx_r} + {{(DIV_W + 1 - X_W){1'b0}}, hcount};
  assign add_y_s = {1'b0, sy_r} + {{(DIV_W + 1 - Y_W){1'b0}}, vcount};
  assign add_c_s = {1'b0, cnt_r} + {{DIV_W{1'b0}}, 1'b1};

  // Next accumulator values including this cycle's pixel; a carry out pins at all-ones.
  always_comb begin
    sum_x_s     = sx_r;
    sum_y_s     = sy_r;
    close_cnt_s = cnt_r;
    close_ovf_s = ovf_r;
    if (hit_s) begin
      sum_x_s     = add_x_s[DIV_W] ? {DIV_W{1'b1}} : add_x_s[DIV_W-1:0];
      sum_y_s     = add_y_s[DIV_W] ? {DIV_W{1'b1}} : add_y_s[DIV_W-1:0];
      close_cnt_s = add_c_s[DIV_W] ? {DIV_W{1'b1}} : add_c_s[DIV_W-1:0];
      close_ovf_s = ovf_r | add_x_s[DIV_W] | add_y_s[DIV_W] | add_c_s[DIV_W];
    end else begin
      close_ovf_s = ovf_r;
    end
  end

  // Running sums: cleared at frame_end so the next frame starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_r  <= {DIV_W{1'b0}};
      sy_r  <= {DIV_W{1'b0}};
      cnt_r <= {DIV_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (frame_end) begin
      sx_r  <= {DIV_W{1'b0}};
      sy_r  <= {DIV_W{1'b0}};
      cnt_r <= {DIV_W{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      sx_r  <= sum_x_s;
      sy_r  <= sum_y_s;
      cnt_r <= close_cnt_s;
      ovf_r <= close_ovf_s;
    end
  end

  // Snapshot of the closing frame; a frame ending while the FSM is busy is not captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hx_r <= {DIV_W{1'b0}};
      hy_r <= {DIV_W{1'b0}};
      hc_r <= {DIV_W{1'b0}};
    end else if (frame_end && snap_en) begin
      hx_r <= sum_x_s;
      hy_r <= sum_y_s;
      hc_r <= close_cnt_s;
    end else begin
      hx_r <= hx_r;
      hy_r <= hy_r;
      hc_r <= hc_r;
    end
  end

  assign hx = hx_r;
  assign hy = hy_r;
  assign hc = hc_r;

endmodule

// File: rtl/centroid_accumulator.sv
// Frame centroid engine: accumulates hit coordinates, runs x_sum/count and
// y_sum/count through the external divider and publishes one result per frame.
module centroid_accumulator
  import centroid_pkg::*;
#(
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int MIN_PIXELS = MIN_PIXELS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_valid,
  input  logic                   pix_hit,
  input  logic [X_W-1:0]         hcount,
  input  logic [Y_W-1:0]         vcount,
  input  logic                   frame_end,
  centroid_accumulator_if.master div_if,
  output logic [X_W-1:0]         centroid_x,
  output logic [Y_W-1:0]         centroid_y,
  output logic                   centroid_valid,
  output logic                   target_found,
  output logic                   frame_dropped,
  output logic                   busy
);

  localparam int               TMO_W    = tmo_width(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state_r, state_n;
  logic             found_r, found_n;
  logic             sel_y_r, sel_y_n;
  logic             start_r, start_n;
  logic [TMO_W-1:0] tmo_r, tmo_n;
  logic [X_W-1:0]   qx_r, qx_n, qx_clamp_s;
  logic [Y_W-1:0]   qy_r, qy_n, qy_clamp_s;
  logic [X_W-1:0]   centroid_x_r;
  logic [Y_W-1:0]   centroid_y_r;
  logic             centroid_valid_r, target_found_r, frame_dropped_r, busy_r;
  logic [DIV_W-1:0] close_cnt_s, hx_s, hy_s, hc_s;
  logic             close_ovf_s;
  logic             snap_en_s;

  assign snap_en_s = (state_r == ST_IDLE);

  centroid_sum_accum #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .DIV_W (DIV_W)
  ) u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_hit     (pix_hit),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_end   (frame_end),
    .snap_en     (snap_en_s),
    .close_cnt_s (close_cnt_s),
    .close_ovf_s (close_ovf_s),
    .hx          (hx_s),
    .hy          (hy_s),
    .hc          (hc_s)
  );

  // Quotients never exceed the largest coordinate; clamp anyway so a faulty divider cannot wrap.
  always_comb begin
    if (|div_if.div_quotient[DIV_W-1:X_W]) begin
      qx_clamp_s = {X_W{1'b1}};
    end else begin
      qx_clamp_s = div_if.div_quotient[X_W-1:0];
    end
    if (|div_if.div_quotient[DIV_W-1:Y_W]) begin
      qy_clamp_s = {Y_W{1'b1}};
    end else begin
      qy_clamp_s = div_if.div_quotient[Y_W-1:0];
    end
  end

  // Next-state logic; div_ready is only honoured in the two WAIT states.
  always_comb begin
    state_n = state_r;
    found_n = found_r;
    sel_y_n = sel_y_r;
    tmo_n   = tmo_r;
    qx_n    = qx_r;
    qy_n    = qy_r;
    start_n = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sel_y_n = 1'b0;
        if (frame_end) begin
          if (close_ovf_s || (close_cnt_s < DIV_W'(MIN_PIXELS))) begin
            state_n = ST_PUBLISH;
            found_n = 1'b0;
          end else begin
            state_n = ST_START_X;
            start_n = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START_X: begin
        state_n = ST_WAIT_X;
        tmo_n   = {TMO_W{1'b0}};
      end
      ST_WAIT_X: begin
        if (div_if.div_ready) begin
          qx_n    = qx_clamp_s;
          sel_y_n = 1'b1;
          start_n = 1'b1;
          state_n = ST_START_Y;
        end else if (tmo_r == TMO_LAST) begin
          found_n = 1'b0;
          state_n = ST_PUBLISH;
        end else begin
          tmo_n = tmo_r + {{(TMO_W - 1){1'b0}}, 1'b1};
        end
      end
      ST_START_Y: begin
        state_n = ST_WAIT_Y;
        tmo_n   = {TMO_W{1'b0}};
      end
      ST_WAIT_Y: begin
        if (div_if.div_ready) begin
          qy_n    = qy_clamp_s;
          found_n = 1'b1;
          state_n = ST_PUBLISH;
        end else if (tmo_r == TMO_LAST) begin
          found_n = 1'b0;
          state_n = ST_PUBLISH;
        end else begin
          tmo_n = tmo_r + {{(TMO_W - 1){1'b0}}, 1'b1};
        end
      end
      ST_PUBLISH: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        found_n = 1'b0;
      end
    endcase
  end

  // FSM state and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      found_r <= 1'b0;
      sel_y_r <= 1'b0;
      start_r <= 1'b0;
      tmo_r   <= {TMO_W{1'b0}};
      qx_r    <= {X_W{1'b0}};
      qy_r    <= {Y_W{1'b0}};
    end else begin
      state_r <= state_n;
      found_r <= found_n;
      sel_y_r <= sel_y_n;
      start_r <= start_n;
      tmo_r   <= tmo_n;
      qx_r    <= qx_n;
      qy_r    <= qy_n;
    end
  end

  // Published results and status pulses; the centroid holds across failed frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      centroid_x_r     <= {X_W{1'b0}};
      centroid_y_r     <= {Y_W{1'b0}};
      centroid_valid_r <= 1'b0;
      target_found_r   <= 1'b0;
      frame_dropped_r  <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      centroid_valid_r <= (state_r == ST_PUBLISH);
      frame_dropped_r  <= frame_end && (state_r != ST_IDLE);
      busy_r           <= (state_n != ST_IDLE);
      if (state_r == ST_PUBLISH) begin
        target_found_r <= found_r;
        if (found_r) begin
          centroid_x_r <= qx_r;
          centroid_y_r <= qy_r;
        end else begin
          centroid_x_r <= centroid_x_r;
          centroid_y_r <= centroid_y_r;
        end
      end else begin
        target_found_r <= target_found_r;
        centroid_x_r   <= centroid_x_r;
        centroid_y_r   <= centroid_y_r;
      end
    end
  end

  assign div_if.div_start    = start_r;
  assign div_if.div_sign     = 1'b0;
  assign div_if.div_dividend = sel_y_r ? hy_s : hx_s;
  assign div_if.div_divisor  = hc_s;

  assign centroid_x     = centroid_x_r;
  assign centroid_y     = centroid_y_r;
  assign centroid_valid = centroid_valid_r;
  assign target_found   = target_found_r;
  assign frame_dropped  = frame_dropped_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_centroid_accumulator.sv
// Scoreboard bench for centroid_accumulator: directed and random frames against
// a sum/count reference model and a behavioural divider.
module tb_centroid_accumulator;

  localparam int X_W        = 10;
  localparam int Y_W        = 10;
  localparam int DIV_W      = 32;
  localparam int MIN_PIXELS = 64;
  localparam int TIMEOUT    = 80;
  localparam int DIV_LAT    = DIV_W + 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pix_valid = 1'b0;
  logic           pix_hit = 1'b0;
  logic [X_W-1:0] hcount = '0;
  logic [Y_W-1:0] vcount = '0;
  logic           frame_end = 1'b0;
  logic [X_W-1:0] centroid_x;
  logic [Y_W-1:0] centroid_y;
  logic           centroid_valid, target_found, frame_dropped, busy;

  centroid_accumulator_if #(.DIV_W(DIV_W)) div_if ();

  centroid_accumulator #(
    .X_W(X_W), .Y_W(Y_W), .DIV_W(DIV_W), .MIN_PIXELS(MIN_PIXELS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pix_valid      (pix_valid),
    .pix_hit        (pix_hit),
    .hcount         (hcount),
    .vcount         (vcount),
    .frame_end      (frame_end),
    .div_if         (div_if),
    .centroid_x     (centroid_x),
    .centroid_y     (centroid_y),
    .centroid_valid (centroid_valid),
    .target_found   (target_found),
    .frame_dropped  (frame_dropped),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; bit found; int lat; int fe; } pub_t;
  typedef struct { longint dvd; longint dvs; } div_exp_t;

  pub_t     pub_q[$];
  div_exp_t div_q[$];
  int       drop_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int starts = 0;
  bit div_hang = 1'b0;

  longint m_sx = 0, m_sy = 0, m_n = 0;
  int     last_x = 0, last_y = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // behavioural divider: ready one pulse DIV_LAT cycles after start, no reset
  initial begin
    int     pend;
    longint p_dvd, p_dvs;
    pend = 0; p_dvd = 0; p_dvs = 1;
    div_if.div_ready = 1'b0;
    div_if.div_quotient = '0;
    forever begin
      @(negedge clk);
      div_if.div_ready = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          div_if.div_ready = 1'b1;
          div_if.div_quotient = (p_dvs == 0) ? '1 : DIV_W'(p_dvd / p_dvs);
        end
      end
      if (div_if.div_start === 1'b1) begin
        starts++;
        if (!div_hang) begin
          pend  = DIV_LAT;
          p_dvd = longint'(div_if.div_dividend);
          p_dvs = longint'(div_if.div_divisor);
        end
      end
    end
  end

  // monitor: pops expected events whenever the DUT presents one
  initial begin
    pub_t     e;
    div_exp_t d;
    forever begin
      @(negedge clk);
      if (centroid_valid === 1'b1) begin
        if (pub_q.size() == 0) begin
          check("unexpected_centroid_valid", centroid_valid, 0);
        end else begin
          e = pub_q.pop_front();
          check("centroid_x", centroid_x, e.x);
          check("centroid_y", centroid_y, e.y);
          check("target_found", target_found, e.found);
          if (e.lat >= 0) check("publish_latency", cyc - e.fe, e.lat);
        end
      end
      if (div_if.div_start === 1'b1) begin
        if (div_q.size() == 0) begin
          check("unexpected_div_start", div_if.div_start, 0);
        end else begin
          d = div_q.pop_front();
          check("div_dividend", div_if.div_dividend, d.dvd);
          check("div_divisor", div_if.div_divisor, d.dvs);
          check("div_sign", div_if.div_sign, 0);
        end
      end
      if (frame_dropped === 1'b1) begin
        if (drop_q.size() == 0) begin
          check("unexpected_frame_dropped", frame_dropped, 0);
        end else begin
          void'(drop_q.pop_front());
          vectors++;
        end
      end
    end
  end

  task automatic pix(input bit v, input bit h, input int x, input int y);
    @(negedge clk);
    pix_valid = v; pix_hit = h; hcount = X_W'(x); vcount = Y_W'(y); frame_end = 1'b0;
    if (v && h) begin
      m_sx += x; m_sy += y; m_n++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0; pix_hit = 1'b0; frame_end = 1'b0;
    end
  endtask

  // frame_end with an optional same-cycle pixel; pushes the expected outcome
  task automatic end_frame(input bit drop, input bit v, input bit h, input int x, input int y);
    @(negedge clk);
    pix_valid = v; pix_hit = h; hcount = X_W'(x); vcount = Y_W'(y); frame_end = 1'b1;
    if (v && h) begin
      m_sx += x; m_sy += y; m_n++;
    end
    if (drop) begin
      drop_q.push_back(cyc);
    end else if (m_n < MIN_PIXELS) begin
      pub_q.push_back('{last_x, last_y, 1'b0, 2, cyc});
    end else begin
      div_q.push_back('{m_sx, m_n});
      if (div_hang) begin
        pub_q.push_back('{last_x, last_y, 1'b0, TIMEOUT + 3, cyc});
      end else begin
        div_q.push_back('{m_sy, m_n});
        last_x = int'(m_sx / m_n);
        last_y = int'(m_sy / m_n);
        pub_q.push_back('{last_x, last_y, 1'b1, -1, cyc});
      end
    end
    m_sx = 0; m_sy = 0; m_n = 0;
    @(negedge clk);
    pix_valid = 1'b0; pix_hit = 1'b0; frame_end = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      idle(1);
      if (pub_q.size() == 0 && div_q.size() == 0 && drop_q.size() == 0 && busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic random_frame(input int nh, input int x0, input int y0, input int span);
    int k;
    k = 0;
    while (k < nh) begin
      case ($urandom_range(0, 3))
        0:       pix(1'b1, 1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023));
        1:       pix(1'b0, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023));
        default: begin
          pix(1'b1, 1'b1, x0 + $urandom_range(0, span), y0 + $urandom_range(0, span));
          k++;
        end
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_centroid_valid", centroid_valid, 0);
    check("reset_div_start", div_if.div_start, 0);
    rst_n = 1'b1;
    idle(3);
    check("idle_centroid_x", centroid_x, 0);
    check("idle_target_found", target_found, 0);
    check("idle_frame_dropped", frame_dropped, 0);

    // 64 hits at (100,50); the last one arrives with frame_end
    for (int i = 0; i < 63; i++) pix(1'b1, 1'b1, 100, 50);
    end_frame(1'b0, 1'b1, 1'b1, 100, 50);
    drain("drain_single_point");

    // 8x8 block x=10..17, y=20..27
    for (int y = 20; y < 28; y++)
      for (int x = 10; x < 18; x++) pix(1'b1, 1'b1, x, y);
    end_frame(1'b0, 1'b0, 1'b0, 0, 0);
    drain("drain_block");

    // too few hits: no division, result two cycles later, centroid held
    for (int i = 0; i < 10; i++) pix(1'b1, 1'b1, 500 + i, 700);
    end_frame(1'b0, 1'b0, 1'b0, 0, 0);
    drain("drain_few_hits");

    // second frame_end while dividing: dropped, first result intact
    random_frame(80, 200, 300, 63);
    end_frame(1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) pix(1'b1, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023));
    end_frame(1'b1, 1'b1, 1'b1, 900, 900);
    drain("drain_drop");
    random_frame(70, 600, 100, 40);
    end_frame(1'b0, 1'b0, 1'b0, 0, 0);
    drain("drain_after_drop");

    // random frames, some below threshold
    for (int f = 0; f < 6; f++) begin
      random_frame($urandom_range(0, 150), $urandom_range(0, 900), $urandom_range(0, 900), 120);
      end_frame(1'b0, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023));
      drain("drain_random");
    end

    // divider never answers: timeout abort from WAIT_X
    div_hang = 1'b1;
    random_frame(70, 50, 60, 30);
    end_frame(1'b0, 1'b0, 1'b0, 0, 0);
    drain("drain_timeout");
    div_hang = 1'b0;
    check("timeout_idle_busy", busy, 0);

    // reset during WAIT_Y; the divider's later ready must be ignored
    s0 = starts;
    random_frame(90, 300, 400, 50);
    end_frame(1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 200 && starts < s0 + 2; i++) idle(1);
    check("reached_wait_y", starts - s0, 2);
    idle(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_centroid_x", centroid_x, 0);
    check("midrst_centroid_y", centroid_y, 0);
    pub_q.delete();
    last_x = 0; last_y = 0;
    idle(3);
    rst_n = 1'b1;
    idle(60);
    check("postrst_busy", busy, 0);
    check("postrst_target_found", target_found, 0);
    check("postrst_centroid_x", centroid_x, 0);

    // normal frame after reset
    random_frame(64, 700, 800, 100);
    end_frame(1'b0, 1'b0, 1'b0, 0, 0);
    drain("drain_final");

    check("leftover_pub", pub_q.size(), 0);
    check("leftover_div", div_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/centroid_accumulator.md
Name: centroid_accumulator

Overview:
- Sits directly upstream of the restoring divider in the motion-tracking path.
- Accumulates x/y coordinate sums and a hit count over the pixel stream for one frame.
- At frame end, sequences two unsigned divisions through the divider: x_sum/count, then y_sum/count.
- Publishes the target centroid once per frame to the DMX pan/tilt mapping logic.

Parameters:
- X_W, 10, width of the hcount coordinate.
- Y_W, 10, width of the vcount coordinate.
- DIV_W, 32, width of the divider operands and of the accumulators; must match the divider WIDTH.
- MIN_PIXELS, 64, minimum hit count required for a valid target.
- TIMEOUT, 80, maximum cycles to wait for div_ready (at least 2*DIV_W+8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- pix_valid  in  1  pixel coordinate on hcount/vcount is valid this cycle.
- pix_hit  in  1  pixel matches the tracked colour.
- hcount  in  X_W  pixel x coordinate.
- vcount  in  Y_W  pixel y coordinate.
- frame_end  in  1  one-cycle pulse marking the end of a frame.
- div_start  out  1  one-cycle start pulse to the divider.
- div_sign  out  1  tied to 0 (unsigned).
- div_dividend  out  DIV_W  sum being divided.
- div_divisor  out  DIV_W  hit count.
- div_quotient  in  DIV_W  divider quotient.
- div_ready  in  1  one-cycle done pulse from the divider.
- centroid_x  out  X_W  last published x.
- centroid_y  out  Y_W  last published y.
- centroid_valid  out  1  one-cycle publish pulse.
- target_found  out  1  last publish carried a valid centroid.
- frame_dropped  out  1  one-cycle pulse when a frame is discarded.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, accumulators 0, state IDLE.
- Divider has no reset, so div_ready is honoured only in WAIT_X/WAIT_Y and ignored in every other state.
- Accumulation runs every cycle, independent of the FSM.
  - Condition: pix_valid & pix_hit.
  - Updates: sx += hcount, sy += vcount, cnt += 1, all zero-extended to DIV_W.
  - Each accumulator saturates at all-ones and sets a sticky ovf flag for the frame.
- frame_end (any state):
  - The same-cycle pixel counts toward the closing frame.
  - At the edge, sx/sy/cnt/ovf are cleared for the next frame.
  - Snapshot hx/hy/hc/hovf is loaded only if state is IDLE.
- FSM states: IDLE, START_X, WAIT_X, START_Y, WAIT_Y, PUBLISH.
  - IDLE, frame_end: snapshot.
    - hovf=1 or hc<MIN_PIXELS: go to PUBLISH with found=0.
    - Otherwise: go to START_X.
  - START_X: div_start=1, div_dividend=hx, div_divisor=hc. Next state WAIT_X.
  - WAIT_X:
    - Operands held stable.
    - On div_ready: latch qx=div_quotient[X_W-1:0], go to START_Y.
    - Cycle counter reaches TIMEOUT: go to PUBLISH with found=0.
  - START_Y/WAIT_Y: same pattern using hy. On div_ready, latch qy, go to PUBLISH with found=1.
  - PUBLISH:
    - centroid_valid=1 for one cycle, target_found=found.
    - centroid_x/y update only when found=1; otherwise they hold their previous values.
    - Next state IDLE.
- frame_end in any non-IDLE state: frame discarded, frame_dropped=1 for one cycle, FSM unaffected.
- Latency from frame_end to centroid_valid:
  - 5 cycles plus the two divider latencies (about 2*(DIV_W+2)+5).
  - 2 cycles when the count test fails.
- Quotient is always ≤ the largest coordinate seen, so truncation to X_W/Y_W is lossless.
- Reset mid-division: immediate return to IDLE; a later stray div_ready has no effect.

Decomposition:
- Package centroid_pkg holds:
  - state enum;
  - DIV_W / MIN_PIXELS defaults;
  - timeout counter width, clog2(TIMEOUT+1).
- Sub-module centroid_sum_accum holds the three saturating accumulators, ovf, clear-on-frame_end and snapshot logic; the FSM stays in the top.

Test Plan:
- 64 hits all at (100,50), then frame_end, with a behavioural divider model (ready DIV_W+2 cycles after start):
  - required divider inputs: dividend 6400 then 3200, divisor 64;
  - required result: centroid_valid once with (100,50), target_found=1.
- 8x8 block of hits, x=10..17, y=20..27 → hc=64, hx=864, hy=1504 → centroid (13,23).
- 10 hits only, then frame_end → no div_start; centroid_valid 2 cycles later, target_found=0, centroid holds the previous (13,23).
- Second frame_end issued 10 cycles after the first, while in WAIT_X → frame_dropped pulse; first result unaffected; accumulators restart from 0.
- rst_n low during WAIT_Y, then the model pulses div_ready → outputs stay 0, no centroid_valid, busy=0.
- Divider model never asserts ready → abort after TIMEOUT=80 cycles in WAIT_X; centroid_valid with target_found=0; FSM back in IDLE.
